sequenciador_ula: RTL

- Command-driven sequencer that replaces the fixed count-indexed control table in front of the X/Y/Z register and ALU datapath.
- Accepts one operation per valid/ready handshake.
- Drives the register-operation codes (Tx, Ty, Tz), the ALU-operation code (Tula) and the operand-input mux select, step by step.
- Reports completion with `done` and rejected opcodes with `err`; sits between the user/command front end and the datapath.

---
 rtl/sequenciador_ula.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sequenciador_ula.sv
// sequenciador_ula
//   Command-driven sequencer for the X/Y/Z register + ALU datapath. It takes
//   one command per valid/ready handshake. It then steps the register codes
//   (Tx/Ty/Tz), the ALU code (Tula) and the operand mux select (op_sel).
//   Completion is signalled on done and illegal opcodes on err.
//
//   Optional feature macro: SEQ_SHIFT_EN
//     defined   -> SHL (8) / SHR (9), the SHIFT state and the shift counter exist.
//     undefined -> opcodes 8/9 are illegal and take the ERR path.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  high exactly while IDLE
//   cmd_op     in   opcode (0..6 ALU ops, 8 SHL, 9 SHR, 15 CLR)
//   cmd_shamt  in   shift count for SHL/SHR
//   op_sel     out  operand mux select (0 = A, 1 = B)
//   Tx/Ty/Tz   out  register-operation codes
//   Tula       out  ALU-operation code
//   busy       out  high whenever not IDLE
//   done       out  one-cycle completion pulse
//   err        out  one-cycle illegal-opcode pulse
module sequenciador_ula #(
    parameter int SHAMT_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [SHAMT_W-1:0] cmd_shamt,
    output logic               op_sel,
    output logic [2:0]         Tx,
    output logic [2:0]         Ty,
    output logic [2:0]         Tz,
    output logic [2:0]         Tula,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [2:0] R_HOLD   = 3'b000;
    localparam logic [2:0] R_LOAD   = 3'b001;
    localparam logic [2:0] R_RESET  = 3'b100;
`ifdef SEQ_SHIFT_EN
    localparam logic [2:0] R_SHIFTR = 3'b010;
    localparam logic [2:0] R_SHIFTL = 3'b011;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDX   = 3'd1,
        S_LDY   = 3'd2,
        S_EXEC  = 3'd3,
`ifdef SEQ_SHIFT_EN
        S_SHIFT = 3'd4,
`endif
        S_CLR   = 3'd5,
        S_ERR   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
        logic       sel;
        logic [2:0] tx;
        logic [2:0] ty;
        logic [2:0] tz;
        logic [2:0] tula;
    } outs_t;

    localparam outs_t OUTS_IDLE = '{ready: 1'b1, default: '0};

    state_t     state, state_nxt;
    outs_t      outs;
    logic       accept;
    logic [2:0] op_q, op_nxt;

    // Moore decode of a state. Outputs are registered from the next state,
    // so they line up with the state register cycle for cycle.
    function automatic outs_t decode(input state_t st, input logic [2:0] op);
        outs_t o;
        o      = '0;
        o.busy = (st != S_IDLE);
        case (st)
            S_IDLE:  o.ready = 1'b1;
            S_LDX:   o.tx    = R_LOAD;
            S_LDY: begin
                o.ty  = R_LOAD;
                o.sel = 1'b1;
            end
            S_EXEC: begin
                o.tz   = R_LOAD;
                o.tula = op;
            end
`ifdef SEQ_SHIFT_EN
            // SHL = 8 and SHR = 9 differ only in bit 0.
            S_SHIFT: o.tz = op[0] ? R_SHIFTR : R_SHIFTL;
`endif
            S_CLR: begin
                o.tx = R_RESET;
                o.ty = R_RESET;
                o.tz = R_RESET;
            end
            S_ERR:   o.err  = 1'b1;
            S_DONE:  o.done = 1'b1;
            default: o = OUTS_IDLE;
        endcase
        return o;
    endfunction

    assign accept = (state == S_IDLE) && cmd_valid;
    // The op seen by the decoder must include the one being latched this edge.
    assign op_nxt = accept ? cmd_op[2:0] : op_q;

`ifdef SEQ_SHIFT_EN
    logic [SHAMT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (accept)
            cnt <= cmd_shamt;
        else if (state == S_SHIFT)
            cnt <= cnt - SHAMT_W'(1);
    end
`else
    logic unused_shamt;
    assign unused_shamt = ^cmd_shamt;
`endif

    always_ff @(posedge clock) begin
        if (accept)
            op_q <= cmd_op[2:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        4'd0, 4'd1, 4'd2, 4'd3,
                        4'd4, 4'd5, 4'd6: state_nxt = S_LDX;
                        4'd15:            state_nxt = S_CLR;
`ifdef SEQ_SHIFT_EN
                        4'd8, 4'd9:       state_nxt = (cmd_shamt == '0) ? S_DONE : S_SHIFT;
`endif
                        default:          state_nxt = S_ERR;
                    endcase
                end
            end
            S_LDX:   state_nxt = S_LDY;
            S_LDY:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_DONE;
`ifdef SEQ_SHIFT_EN
            // Counter holds the remaining shifts including the current one.
            S_SHIFT: state_nxt = (cnt == SHAMT_W'(1)) ? S_DONE : S_SHIFT;
`endif
            S_CLR:   state_nxt = S_DONE;
            S_ERR:   state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            outs  <= OUTS_IDLE;
        end else begin
            state <= state_nxt;
            outs  <= decode(state_nxt, op_nxt);
        end
    end

    assign cmd_ready = outs.ready;
    assign busy      = outs.busy;
    assign done      = outs.done;
    assign err       = outs.err;
    assign op_sel    = outs.sel;
    assign Tx        = outs.tx;
    assign Ty        = outs.ty;
    assign Tz        = outs.tz;
    assign Tula      = outs.tula;

endmodule
